// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller
// and its hazard-detection helper.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Data-cache miss handshake between the MEM stage, the cache and the
// stall controller.
// Handshake: dmem_req_o rises the cycle after a miss is seen and stays high
// until the cache returns dmem_ack_i (or the wait times out). dmem_ack_i is
// only meaningful while dmem_req_o is high; the ack cycle is the last cycle of
// the request.
interface pipeline_stall_ctrl_if;
    logic EXMEM_MemOp_i;
    logic dmem_hit_i;
    logic dmem_ack_i;
    logic dmem_req_o;

    modport master (
        input  EXMEM_MemOp_i,
        input  dmem_hit_i,
        input  dmem_ack_i,
        output dmem_req_o
    );

    modport slave (
        output EXMEM_MemOp_i,
        output dmem_hit_i,
        output dmem_ack_i,
        input  dmem_req_o
    );
endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the
// instruction in ID. Writes to the zero register never create a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       load_use_o
);

    always_comb begin
        load_use_o = idex_mem_read_i
                     && (idex_rt_i != REG_ZERO)
                     && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: prioritises data-cache miss stalls over
// load-use bubbles over taken-branch flushes, and runs the cache handshake.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 32
) (
    input  logic                 Clock_i,
    input  logic                 Reset_n_i,
    pipeline_stall_ctrl_if.master dmem,
    input  logic                 IDEX_MemRead_i,
    input  logic [4:0]           IDEX_Rt_i,
    input  logic [4:0]           IFID_Rs_i,
    input  logic [4:0]           IFID_Rt_i,
    input  logic                 branch_taken_i,
    output logic                 PC_stall_o,
    output logic                 IFID_stall_o,
    output logic                 IFID_flush_o,
    output logic                 IDEX_stall_o,
    output logic                 IDEX_bubble_o,
    output logic                 EXMEM_stall_o,
    output logic                 MEMWB_stall_o,
    output logic                 timeout_o,
    output logic [CNT_W-1:0]     stall_cycles_o,
    output state_e               state_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   req_q, req_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    logic miss;
    logic timeout_now;
    logic mem_stall;
    logic load_use;
    logic load_use_eff;
    logic pc_stall;

    hazard_detect u_hazard_detect (
        .idex_mem_read_i (IDEX_MemRead_i),
        .idex_rt_i       (IDEX_Rt_i),
        .ifid_rs_i       (IFID_Rs_i),
        .ifid_rt_i       (IFID_Rt_i),
        .load_use_o      (load_use)
    );

    // The ack cycle (and a timeout cycle) releases the stall so MEM/WB captures
    // at that edge.
    always_comb begin
        miss         = dmem.EXMEM_MemOp_i && !dmem.dmem_hit_i;
        timeout_now  = (state_q == WAIT) && !dmem.dmem_ack_i && (wait_cnt_q == WAIT_LAST);
        mem_stall    = ((state_q == IDLE) && miss)
                       || ((state_q == WAIT) && !dmem.dmem_ack_i && !timeout_now);
        load_use_eff = load_use && !mem_stall;
        pc_stall     = mem_stall || load_use_eff;

        PC_stall_o    = pc_stall;
        IFID_stall_o  = pc_stall;
        IFID_flush_o  = branch_taken_i && !mem_stall && !load_use;
        IDEX_stall_o  = mem_stall;
        IDEX_bubble_o = load_use_eff;
        EXMEM_stall_o = mem_stall;
        MEMWB_stall_o = mem_stall;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            WAIT: begin
                if (dmem.dmem_ack_i) begin
                    state_d = IDLE;
                end else if (timeout_now) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        req_d = (state_d == WAIT);

        stall_cnt_d = stall_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            req_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            req_q       <= req_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign dmem.dmem_req_o = req_q;
    assign timeout_o       = timeout_q;
    assign stall_cycles_o  = stall_cnt_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: each step pushes its expected
// output vector, a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;

  // control order: pc, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem, memwb
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_MS   = 7'b1101011;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_FL   = 7'b0010000;

  logic             clk;
  logic             rst_n;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             branch_taken;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic             exmem_stall, memwb_stall, timeout;
  logic [CNT_W-1:0] stall_cycles;
  state_e           state;

  pipeline_stall_ctrl_if dmem_if ();

  pipeline_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .Clock_i        (clk),
    .Reset_n_i      (rst_n),
    .dmem           (dmem_if),
    .IDEX_MemRead_i (idex_mem_read),
    .IDEX_Rt_i      (idex_rt),
    .IFID_Rs_i      (ifid_rs),
    .IFID_Rt_i      (ifid_rt),
    .branch_taken_i (branch_taken),
    .PC_stall_o     (pc_stall),
    .IFID_stall_o   (ifid_stall),
    .IFID_flush_o   (ifid_flush),
    .IDEX_stall_o   (idex_stall),
    .IDEX_bubble_o  (idex_bubble),
    .EXMEM_stall_o  (exmem_stall),
    .MEMWB_stall_o  (memwb_stall),
    .timeout_o      (timeout),
    .stall_cycles_o (stall_cycles),
    .state_o        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, steps_left=%0d want=0", exp_q.size());
    $fatal(1, "bench did not terminate");
  end

  // scoreboard
  logic [12:0] exp_q[$];
  int          tag_q[$];
  int          total = 0;
  int          bad   = 0;
  int          step_n = 0;

  function automatic logic [12:0] ex(input logic [6:0] c, input logic req, input logic to,
                                     input logic [3:0] cnt);
    return {c, req, to, cnt};
  endfunction

  always @(negedge clk) begin
    logic [12:0] got;
    logic [12:0] want;
    int          tag;
    if (exp_q.size() != 0) begin
      got  = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble, exmem_stall,
              memwb_stall, dmem_if.dmem_req_o, timeout, stall_cycles};
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL step%0d ctrl7/req/to/cnt got=%b want=%b", tag, got, want);
      end
    end
  end

  // driver
  task automatic step(input logic mo, input logic hit, input logic ack, input logic rd,
                      input logic [4:0] xrt, input logic [4:0] frs, input logic [4:0] frt,
                      input logic br, input logic [12:0] e, input logic rst_pulse);
    @(posedge clk);
    #1;
    dmem_if.EXMEM_MemOp_i = mo;
    dmem_if.dmem_hit_i    = hit;
    dmem_if.dmem_ack_i    = ack;
    idex_mem_read         = rd;
    idex_rt               = xrt;
    ifid_rs               = frs;
    ifid_rt               = frt;
    branch_taken          = br;
    exp_q.push_back(e);
    tag_q.push_back(step_n);
    step_n++;
    if (rst_pulse) begin
      #1 rst_n = 1'b0;
      #5 rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n                 = 1'b0;
    dmem_if.EXMEM_MemOp_i = 1'b0;
    dmem_if.dmem_hit_i    = 1'b0;
    dmem_if.dmem_ack_i    = 1'b0;
    idex_mem_read         = 1'b0;
    idex_rt               = 5'd0;
    ifid_rs               = 5'd0;
    ifid_rt               = 5'd0;
    branch_taken          = 1'b0;
    #12 rst_n = 1'b1;

    // reset state, idle
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,0), 0);
    // miss at cycle 0, ack at cycle 3
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,0,0,0), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,1,0,1), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,1,0,2), 0);
    step(1,0,1,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,1,0,3), 0);
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,3), 0);
    // hit: no stall
    step(1,1,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,3), 0);
    // load-use on Rs, zero reg, on Rt, not a load
    step(0,0,0,1, 5'd5,5'd5,5'd0, 0, ex(C_LU,0,0,3), 0);
    step(0,0,0,1, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,4), 0);
    step(0,0,0,1, 5'd7,5'd1,5'd7, 0, ex(C_LU,0,0,4), 0);
    step(0,0,0,0, 5'd5,5'd5,5'd0, 0, ex(C_NONE,0,0,5), 0);
    // branch alone, then branch under load-use
    step(0,0,0,0, 5'd0,5'd0,5'd0, 1, ex(C_FL,0,0,5), 0);
    step(0,0,0,1, 5'd5,5'd0,5'd5, 1, ex(C_LU,0,0,5), 0);
    // branch (and load-use) during a miss: flush deferred to ack cycle
    step(1,0,0,1, 5'd5,5'd5,5'd0, 1, ex(C_MS,0,0,6), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 1, ex(C_MS,1,0,7), 0);
    step(1,0,1,0, 5'd0,5'd0,5'd0, 1, ex(C_FL,1,0,8), 0);
    // minimum penalty, back-to-back misses
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,0,0,8), 0);
    step(1,0,1,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,1,0,9), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,0,0,9), 0);
    step(1,0,1,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,1,0,10), 0);
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,10), 0);
    // no ack: timeout after 4 WAIT cycles, sticky; ack ignored in IDLE
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,0,0,10), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,1,0,11), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,1,0,12), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,1,0,13), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,1,0,14), 0);
    step(0,0,1,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,1,14), 0);
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,1,14), 0);
    // stall counter saturates at 15
    step(0,0,0,1, 5'd3,5'd3,5'd0, 0, ex(C_LU,0,1,14), 0);
    step(0,0,0,1, 5'd3,5'd3,5'd0, 0, ex(C_LU,0,1,15), 0);
    step(0,0,0,1, 5'd3,5'd3,5'd0, 0, ex(C_LU,0,1,15), 0);
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,1,15), 0);
    // reset pulse in the second WAIT cycle, then a normal miss
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,0,1,15), 0);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,1,1,15), 0);
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,0), 1);
    step(1,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_MS,0,0,0), 0);
    step(1,0,1,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,1,0,1), 0);
    step(0,0,0,0, 5'd0,5'd0,5'd0, 0, ex(C_NONE,0,0,1), 0);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want=0", exp_q.size());
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
